// File: rtl/wave_seq_ctrl.sv
// Phase-accumulator sequencer for the waveform ROM: continuous or N-period burst playback,
// with shadowed reconfiguration applied at period wraps. Optional sweep: WAVE_SEQ_SWEEP_EN.
module wave_seq_ctrl #(
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned ROM_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ACC_W-1:0] cfg_ftw,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_cycles,
  input  logic [ACC_W-1:0] cfg_step,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic             rom_en,
  output logic [1:0]       rom_select,
  output logic [7:0]       rom_phase,
  output logic             sample_valid
);

  localparam int unsigned PH_W  = 8;
  localparam int unsigned DRN_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DRN_W-1:0]   drn_q, drn_d;
  logic               pending_q, pending_d;
  logic [ACC_W-1:0]   sh_ftw_q, sh_ftw_d;
  logic [1:0]         sh_sel_q, sh_sel_d;
  logic [CNT_W-1:0]   sh_cyc_q, sh_cyc_d;
  logic [ACC_W-1:0]   act_ftw_q, act_ftw_d;
  logic [CNT_W-1:0]   act_cyc_q, act_cyc_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rom_en_q, rom_en_d;
  logic [1:0]         rom_sel_q, rom_sel_d;
  logic [ROM_LAT-1:0] sv_q, sv_d;

  logic               cfg_fire_c;
  logic [ACC_W:0]     sum_c;
  logic               wrap_c;
  logic               terminal_c;

`ifdef WAVE_SEQ_SWEEP_EN
  logic [ACC_W-1:0]   sh_step_q, sh_step_d;
  logic [ACC_W-1:0]   act_step_q, act_step_d;
  logic [ACC_W:0]     sweep_c;

  assign sweep_c = {1'b0, act_ftw_q} + {1'b0, act_step_q};
`else
  logic               step_unused_c;

  assign step_unused_c = ^cfg_step;
`endif

  assign cfg_fire_c = cfg_valid & cfg_ready_q;
  assign sum_c      = {1'b0, acc_q} + {1'b0, act_ftw_q};
  assign wrap_c     = sum_c[ACC_W];
  // Last wrap of a burst; continuous mode (cycles == 0) never terminates on its own
  assign terminal_c = wrap_c && (act_cyc_q != '0) &&
                      (((CNT_W+1)'(count_q) + (CNT_W+1)'(1)) == (CNT_W+1)'(act_cyc_q));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    drn_d     = drn_q;
    pending_d = pending_q;
    sh_ftw_d  = sh_ftw_q;
    sh_sel_d  = sh_sel_q;
    sh_cyc_d  = sh_cyc_q;
    act_ftw_d = act_ftw_q;
    act_cyc_d = act_cyc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rom_en_d  = rom_en_q;
    rom_sel_d = rom_sel_q;
`ifdef WAVE_SEQ_SWEEP_EN
    sh_step_d  = sh_step_q;
    act_step_d = act_step_q;
`endif

    if (cfg_fire_c) begin
      sh_ftw_d = cfg_ftw;
      sh_sel_d = cfg_sel;
      sh_cyc_d = cfg_cycles;
`ifdef WAVE_SEQ_SWEEP_EN
      sh_step_d = cfg_step;
`endif
    end

    case (state_q)
      S_IDLE: begin
        acc_d    = '0;
        rom_en_d = 1'b0;
        busy_d   = 1'b0;
        // A config landing in the same cycle as start is the one launched
        if (start && (sh_ftw_d != '0)) begin
          state_d   = S_RUN;
          act_ftw_d = sh_ftw_d;
          act_cyc_d = sh_cyc_d;
          rom_sel_d = sh_sel_d;
`ifdef WAVE_SEQ_SWEEP_EN
          act_step_d = sh_step_d;
`endif
          count_d   = '0;
          pending_d = 1'b0;
          rom_en_d  = 1'b1;
          busy_d    = 1'b1;
        end
      end

      S_RUN: begin
        acc_d = sum_c[ACC_W-1:0];
        if (cfg_fire_c) begin
          pending_d = 1'b1;
        end
        if (stop || terminal_c) begin
          state_d  = S_DRAIN;
          rom_en_d = 1'b0;
          drn_d    = DRN_W'(ROM_LAT - 1);
          done_d   = (ROM_LAT == 32'd1);
        end else if (wrap_c) begin
          // Period boundary: swap in a pending config so no partial period is emitted
          if (pending_q) begin
            act_ftw_d = sh_ftw_q;
            act_cyc_d = sh_cyc_q;
            rom_sel_d = sh_sel_q;
`ifdef WAVE_SEQ_SWEEP_EN
            act_step_d = sh_step_q;
`endif
            count_d   = '0;
            pending_d = 1'b0;
          end else begin
            count_d = count_q + CNT_W'(1);
`ifdef WAVE_SEQ_SWEEP_EN
            act_ftw_d = sweep_c[ACC_W] ? {ACC_W{1'b1}} : sweep_c[ACC_W-1:0];
`endif
          end
        end
      end

      S_DRAIN: begin
        acc_d    = '0;
        rom_en_d = 1'b0;
        if (drn_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          drn_d  = drn_q - DRN_W'(1);
          done_d = (drn_q == DRN_W'(1));
        end
      end

      default: begin
        state_d  = S_IDLE;
        acc_d    = '0;
        rom_en_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase

    cfg_ready_d = ~pending_d;
    sv_d        = ROM_LAT'({sv_q, rom_en_q});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      drn_q       <= '0;
      pending_q   <= 1'b0;
      sh_ftw_q    <= '0;
      sh_sel_q    <= '0;
      sh_cyc_q    <= '0;
      act_ftw_q   <= '0;
      act_cyc_q   <= '0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rom_en_q    <= 1'b0;
      rom_sel_q   <= '0;
      sv_q        <= '0;
`ifdef WAVE_SEQ_SWEEP_EN
      sh_step_q   <= '0;
      act_step_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      drn_q       <= drn_d;
      pending_q   <= pending_d;
      sh_ftw_q    <= sh_ftw_d;
      sh_sel_q    <= sh_sel_d;
      sh_cyc_q    <= sh_cyc_d;
      act_ftw_q   <= act_ftw_d;
      act_cyc_q   <= act_cyc_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rom_en_q    <= rom_en_d;
      rom_sel_q   <= rom_sel_d;
      sv_q        <= sv_d;
`ifdef WAVE_SEQ_SWEEP_EN
      sh_step_q   <= sh_step_d;
      act_step_q  <= act_step_d;
`endif
    end
  end

  assign cfg_ready    = cfg_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign rom_en       = rom_en_q;
  assign rom_select   = rom_sel_q;
  assign rom_phase    = acc_q[ACC_W-1 -: PH_W];
  assign sample_valid = sv_q[ROM_LAT-1];

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Bench for wave_seq_ctrl: behavioural model compared every cycle, directed scenarios
// with literal expectations, then randomized stimulus.
module tb_wave_seq_ctrl;

  localparam int unsigned ACC_W   = 16;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned ROM_LAT = 2;
  localparam longint unsigned MOD = longint'(1) << ACC_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [ACC_W-1:0] cfg_ftw = '0;
  logic [1:0]       cfg_sel = '0;
  logic [CNT_W-1:0] cfg_cycles = '0;
  logic [ACC_W-1:0] cfg_step = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             busy, done, rom_en, sample_valid;
  logic [1:0]       rom_select;
  logic [7:0]       rom_phase;

  always #5 clk = ~clk;

  wave_seq_ctrl #(.ACC_W(ACC_W), .CNT_W(CNT_W), .ROM_LAT(ROM_LAT)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ftw(cfg_ftw), .cfg_sel(cfg_sel), .cfg_cycles(cfg_cycles), .cfg_step(cfg_step),
    .start(start), .stop(stop),
    .busy(busy), .done(done),
    .rom_en(rom_en), .rom_select(rom_select), .rom_phase(rom_phase),
    .sample_valid(sample_valid)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: player mode 0=idle 1=playing 2=draining, phase as plain integer arithmetic
  int              m_mode, m_cnt, m_left;
  bit              m_pend;
  longint unsigned m_acc, sh_ftw, sh_step, a_ftw, a_step;
  int              sh_sel, sh_cyc, a_sel, a_cyc;
  bit              e_ready, e_busy, e_done, e_en, e_sv;
  int              e_sel, e_phase;
  bit              en_hist[$];

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_left = 0; m_pend = 0; m_acc = 0;
    sh_ftw = 0; sh_step = 0; sh_sel = 0; sh_cyc = 0;
    a_ftw = 0; a_step = 0; a_sel = 0; a_cyc = 0;
    e_ready = 1; e_busy = 0; e_done = 0; e_en = 0; e_sv = 0; e_sel = 0; e_phase = 0;
    en_hist = {};
    repeat (ROM_LAT) en_hist.push_back(1'b0);
  endtask

  task automatic model_step();
    bit fire, wrap, term, pend_old;
    longint unsigned n_ftw, n_step, nacc;
    int n_sel, n_cyc;
    fire   = cfg_valid && !m_pend;
    n_ftw  = fire ? longint'(cfg_ftw) : sh_ftw;
    n_step = fire ? longint'(cfg_step) : sh_step;
    n_sel  = fire ? int'(cfg_sel) : sh_sel;
    n_cyc  = fire ? int'(cfg_cycles) : sh_cyc;
    if (m_mode == 0) begin
      m_acc = 0;
      if (start && n_ftw != 0) begin
        m_mode = 1; a_ftw = n_ftw; a_step = n_step; a_sel = n_sel; a_cyc = n_cyc;
        m_cnt = 0; m_pend = 0;
      end
    end else if (m_mode == 1) begin
      nacc = m_acc + a_ftw;
      wrap = (nacc >= MOD);
      m_acc = nacc % MOD;
      term = wrap && a_cyc != 0 && (m_cnt + 1 == a_cyc);
      pend_old = m_pend;
      if (fire) m_pend = 1;
      if (stop || term) begin
        m_mode = 2; m_left = ROM_LAT;
      end else if (wrap) begin
        if (pend_old) begin
          a_ftw = sh_ftw; a_step = sh_step; a_sel = sh_sel; a_cyc = sh_cyc;
          m_cnt = 0; m_pend = 0;
        end else begin
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
`ifdef WAVE_SEQ_SWEEP_EN
          a_ftw = (a_ftw + a_step > MOD - 1) ? MOD - 1 : a_ftw + a_step;
`endif
        end
      end
    end else begin
      m_left--;
      m_acc = 0;
      if (m_left == 0) m_mode = 0;
    end
    sh_ftw = n_ftw; sh_step = n_step; sh_sel = n_sel; sh_cyc = n_cyc;
    e_busy  = (m_mode != 0);
    e_en    = (m_mode == 1);
    e_done  = (m_mode == 2) && (m_left == 1);
    e_ready = !m_pend;
    e_sel   = a_sel;
    e_phase = int'((m_acc >> (ACC_W - 8)) & 64'hFF);
    en_hist.push_back(e_en);
    e_sv = en_hist.pop_front();
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_cfg_ready", 32'(cfg_ready), 32'(e_ready));
      chk("m_busy", 32'(busy), 32'(e_busy));
      chk("m_done", 32'(done), 32'(e_done));
      chk("m_rom_en", 32'(rom_en), 32'(e_en));
      chk("m_rom_select", 32'(rom_select), 32'(e_sel));
      chk("m_sample_valid", 32'(sample_valid), 32'(e_sv));
      if (e_en) chk("m_rom_phase", 32'(rom_phase), 32'(e_phase));
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [ACC_W-1:0] f, input logic [1:0] s,
                           input logic [CNT_W-1:0] c, input logic [ACC_W-1:0] st);
    cfg_valid = 1'b1; cfg_ftw = f; cfg_sel = s; cfg_cycles = c; cfg_step = st;
    wait_edges(1);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    wait_edges(1);
    start = 1'b0;
  endtask

  task automatic stop_and_drain();
    stop = 1'b1;
    wait_edges(1);
    stop = 1'b0;
    wait_edges(ROM_LAT + 2);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rom_en"}, 32'(rom_en), 32'd0);
    chk({tag, "_rom_select"}, 32'(rom_select), 32'd0);
    chk({tag, "_rom_phase"}, 32'(rom_phase), 32'd0);
    chk({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
  endtask

  int ndone;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    chk_reset_outputs("por");

    // start with ftw=0 ignored; then config + start in the same cycle
    pulse_start();
    chk("zero_ftw_busy", 32'(busy), 32'd0);
    cfg_valid = 1'b1; cfg_ftw = 16'h2000; cfg_sel = 2'b01; cfg_cycles = '0; start = 1'b1;
    wait_edges(1);
    cfg_valid = 1'b0; start = 1'b0;
    chk("same_cyc_busy", 32'(busy), 32'd1);
    chk("same_cyc_sel", 32'(rom_select), 32'd1);
    wait_edges(3);
    chk("same_cyc_phase", 32'(rom_phase), 32'h60);
    stop_and_drain();

    // burst of 3 periods at ftw=0x1000
    write_cfg(16'h1000, 2'b11, 8'd3, '0);
    pulse_start();
    chk("burst_en_t1", 32'(rom_en), 32'd1);
    chk("burst_ph_t1", 32'(rom_phase), 32'h00);
    wait_edges(1);
    chk("burst_sv_t2", 32'(sample_valid), 32'd0);
    wait_edges(1);
    chk("burst_sv_t3", 32'(sample_valid), 32'd1);
    wait_edges(3);
    chk("burst_ph_t6", 32'(rom_phase), 32'h50);
    wait_edges(42);
    chk("burst_en_t48", 32'(rom_en), 32'd1);
    chk("burst_ph_t48", 32'(rom_phase), 32'hF0);
    wait_edges(1);
    chk("burst_en_t49", 32'(rom_en), 32'd0);
    chk("burst_done_t49", 32'(done), 32'd0);
    wait_edges(1);
    chk("burst_done_t50", 32'(done), 32'd1);
    chk("burst_busy_t50", 32'(busy), 32'd1);
    wait_edges(1);
    chk("burst_busy_t51", 32'(busy), 32'd0);
    chk("burst_done_t51", 32'(done), 32'd0);
    chk("burst_sv_t51", 32'(sample_valid), 32'd0);
    wait_edges(2);

    // continuous with mid-period reconfiguration
    write_cfg(16'h0800, 2'b00, 8'd0, '0);
    pulse_start();
    wait_edges(8);
    write_cfg(16'h1000, 2'b10, 8'd0, '0);
    chk("recfg_ready_low", 32'(cfg_ready), 32'd0);
    wait_edges(22);
    chk("recfg_sel_before", 32'(rom_select), 32'd0);
    chk("recfg_ready_before", 32'(cfg_ready), 32'd0);
    chk("recfg_ph_before", 32'(rom_phase), 32'hF8);
    wait_edges(1);
    chk("recfg_sel_after", 32'(rom_select), 32'd2);
    chk("recfg_ready_after", 32'(cfg_ready), 32'd1);
    chk("recfg_ph_after", 32'(rom_phase), 32'h00);
    wait_edges(1);
    chk("recfg_ph_step", 32'(rom_phase), 32'h10);
    stop_and_drain();

    // stop coinciding with the terminal wrap
    write_cfg(16'h8000, 2'b00, 8'd1, '0);
    pulse_start();
    wait_edges(1);
    stop = 1'b1;
    wait_edges(1);
    stop = 1'b0;
    chk("stopterm_en", 32'(rom_en), 32'd0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) ndone++;
      if (i == 1) chk("stopterm_done_t4", 32'(done), 32'd1);
      if (i == 2) chk("stopterm_busy_t5", 32'(busy), 32'd0);
      wait_edges(1);
    end
    chk("stopterm_done_count", 32'(ndone), 32'd1);

    // config pending at the terminal wrap survives into the next start
    write_cfg(16'h8000, 2'b01, 8'd2, '0);
    pulse_start();
    wait_edges(2);
    write_cfg(16'h4000, 2'b11, 8'd0, '0);
    chk("pendterm_ready", 32'(cfg_ready), 32'd0);
    wait_edges(1);
    chk("pendterm_en", 32'(rom_en), 32'd0);
    chk("pendterm_sel_kept", 32'(rom_select), 32'd1);
    wait_edges(4);
    chk("pendterm_idle_busy", 32'(busy), 32'd0);
    chk("pendterm_idle_ready", 32'(cfg_ready), 32'd0);
    pulse_start();
    chk("pendterm_ready_clr", 32'(cfg_ready), 32'd1);
    chk("pendterm_sel_new", 32'(rom_select), 32'd3);
    wait_edges(3);
    chk("pendterm_ph", 32'(rom_phase), 32'hC0);
    stop_and_drain();

    // asynchronous reset mid-run clears shadow too
    write_cfg(16'h0400, 2'b10, 8'd0, '0);
    pulse_start();
    wait_edges(10);
    #3 rst = 1'b1;
    #1 chk_reset_outputs("midrun_rst");
    #1 rst = 1'b0;
    wait_edges(1);
    pulse_start();
    chk("post_rst_start_busy", 32'(busy), 32'd0);
    wait_edges(3);
    chk("post_rst_start_en", 32'(rom_en), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      cfg_valid = ($urandom_range(0, 99) < 25);
      case ($urandom_range(0, 7))
        0:       cfg_ftw = '0;
        1:       cfg_ftw = ACC_W'($urandom);
        default: cfg_ftw = ACC_W'($urandom_range(32'h0200, 32'h3000));
      endcase
      cfg_sel    = 2'($urandom_range(0, 3));
      cfg_cycles = CNT_W'($urandom_range(0, 4));
      cfg_step   = ACC_W'($urandom_range(0, 32'h0400));
      start      = ($urandom_range(0, 99) < 8);
      stop       = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 999) < 3) begin
        rst = 1'b1;
        wait_edges(1);
        rst = 1'b0;
      end
      wait_edges(1);
    end
    cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    wait_edges(ROM_LAT + 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
